// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed N-digit hex 7-segment driver. One shared segment bus is
//   strobed across N_DIGITS one-hot digit enables. The display value is double
//   buffered: loads land in a holding register and are copied to the shadow
//   (displayed) register only at a frame wrap, so a frame never mixes digits
//   from two values. Each digit slot starts with BLANK_CYC cycles of all
//   strobes off to suppress ghosting on the shared segment lines.
//
//   Optional feature: define SEG7_LZ_BLANK_EN for leading-zero suppression
//   (digit i>0 has its segments blanked when nibbles i..N_DIGITS-1 are all 0;
//   strobe timing and dp are unaffected; digit 0 is never suppressed).
//
// Parameters
//   N_DIGITS   number of digits (>=1)
//   SCAN_DIV   clk cycles per digit slot (>=2)
//   BLANK_CYC  blank cycles at the start of each slot (0..SCAN_DIV-1)
//   ACTIVE_LOW 1: seg, dp and dig_en are inverted at the pins
//
// Ports
//   clk        system clock
//   rst_n      synchronous reset, active-low
//   en         scan enable; 0 freezes the scan and blanks the outputs
//   load       capture value_in/dp_in
//   value_in   nibble i drives digit i (digit 0 = value_in[3:0])
//   dp_in      decimal point per digit
//   seg        {a,b,c,d,e,f,g}, a = MSB (registered)
//   dp         decimal point of the active digit (registered)
//   dig_en     one-hot digit strobe (registered)
//   frame_done high during the cycle whose clock edge wraps the frame
module seg7_scan_driver #(
  parameter int N_DIGITS   = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     dig_en,
  output logic                    frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0]       PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
  // Pin-level "off" patterns; XOR-ing a logical value with these applies polarity.
  localparam logic [6:0]          SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic                DP_OFF  = (ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] hold_val_q, hold_val_d, shad_val_q, shad_val_d;
  logic [N_DIGITS-1:0]   hold_dp_q, hold_dp_d, shad_dp_q, shad_dp_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   dig_en_q, dig_en_d;

  logic                  last_slot;
  logic                  wrap;
  logic                  active;
  logic [3:0]            nib;
  logic                  nib_dp;
  logic                  lz_blank;
  logic [6:0]            seg_log;
  logic [N_DIGITS-1:0]   dig_log;
`ifdef SEG7_LZ_BLANK_EN
  logic                  upper_nz;
`endif

  always_comb begin
    last_slot  = (pcnt_q == PCNT_LAST);
    wrap       = en && last_slot && (idx_q == IDX_LAST);

    pcnt_d     = pcnt_q;
    idx_d      = idx_q;
    hold_val_d = hold_val_q;
    hold_dp_d  = hold_dp_q;
    shad_val_d = shad_val_q;
    shad_dp_d  = shad_dp_q;
    pending_d  = pending_q;

    if (en) begin
      if (last_slot) begin
        pcnt_d = '0;
        idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end

    if (load) begin
      hold_val_d = value_in;
      hold_dp_d  = dp_in;
    end

    // A load coinciding with the wrap bypasses the holding stage so it is
    // visible from digit 0 of the very next frame.
    if (wrap && load) begin
      shad_val_d = value_in;
      shad_dp_d  = dp_in;
      pending_d  = 1'b0;
    end else begin
      if (wrap && pending_q) begin
        shad_val_d = hold_val_q;
        shad_dp_d  = hold_dp_q;
        pending_d  = 1'b0;
      end
      if (load) pending_d = 1'b1;
    end

    // Digit selection from the current (pre-edge) scan position.
    nib     = 4'h0;
    nib_dp  = 1'b0;
    dig_log = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib        = shad_val_q[4*i +: 4];
        nib_dp     = shad_dp_q[i];
        dig_log[i] = 1'b1;
      end
    end

`ifdef SEG7_LZ_BLANK_EN
    upper_nz = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if ((IW'(i) >= idx_q) && (shad_val_q[4*i +: 4] != 4'h0)) upper_nz = 1'b1;
    end
    lz_blank = (idx_q != '0) && !upper_nz;
`else
    lz_blank = 1'b0;
`endif

    seg_log = lz_blank ? 7'h00 : decode(nib);
    active  = en && (int'(pcnt_q) >= BLANK_CYC);

    if (active) begin
      seg_d    = seg_log ^ SEG_OFF;
      dp_d     = nib_dp ^ DP_OFF;
      dig_en_d = dig_log ^ DIG_OFF;
    end else begin
      seg_d    = SEG_OFF;
      dp_d     = DP_OFF;
      dig_en_d = DIG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      hold_val_q <= '0;
      hold_dp_q  <= '0;
      shad_val_q <= '0;
      shad_dp_q  <= '0;
      pending_q  <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      dig_en_q   <= DIG_OFF;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      hold_val_q <= hold_val_d;
      hold_dp_q  <= hold_dp_d;
      shad_val_q <= shad_val_d;
      shad_dp_q  <= shad_dp_d;
      pending_q  <= pending_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_en_q   <= dig_en_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_en     = dig_en_q;
  assign frame_done = wrap && rst_n;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en;
  logic        load_a, load_b, load_c;
  logic [15:0] val_a, val_c;
  logic [3:0]  val_b;
  logic [3:0]  dpi_a, dpi_c;
  logic        dpi_b;
  logic [6:0]  seg_a, seg_b, seg_c;
  logic        dp_a, dp_b, dp_c;
  logic [3:0]  dig_a, dig_c;
  logic        dig_b;
  logic        fd_a, fd_b, fd_c;

  int total = 0;
  int bad   = 0;

  // A: 4 digits, 4 cyc/slot, 1 blank, active-high
  seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load_a), .value_in(val_a), .dp_in(dpi_a),
    .seg(seg_a), .dp(dp_a), .dig_en(dig_a), .frame_done(fd_a));
  // B: 1 digit, 2 cyc/slot, no blank, active-low
  seg7_scan_driver #(.N_DIGITS(1), .SCAN_DIV(2), .BLANK_CYC(0), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load_b), .value_in(val_b), .dp_in(dpi_b),
    .seg(seg_b), .dp(dp_b), .dig_en(dig_b), .frame_done(fd_b));
  // C: 4 digits, 5 cyc/slot, 2 blank, active-low
  seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(5), .BLANK_CYC(2), .ACTIVE_LOW(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load_c), .value_in(val_c), .dp_in(dpi_c),
    .seg(seg_c), .dp(dp_c), .dig_en(dig_c), .frame_done(fd_c));

  localparam int NDV [3] = '{4, 1, 4};
  localparam int SDV [3] = '{4, 2, 5};
  localparam int BLV [3] = '{1, 0, 2};
  localparam int ALV [3] = '{0, 1, 1};
  localparam logic [6:0] DEC [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
    7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Reference model: scan position derived from a count of enabled ticks.
  int          tick  [3];
  logic [15:0] shown [3];
  logic [3:0]  shdp  [3];
  logic [15:0] held  [3];
  logic [3:0]  hldp  [3];
  bit          pend  [3];
  logic [6:0]  e_seg [3];
  logic        e_dp  [3];
  logic [3:0]  e_dig [3];

  function automatic logic in_load(int m);
    return (m == 0) ? load_a : (m == 1) ? load_b : load_c;
  endfunction
  function automatic logic [15:0] in_val(int m);
    return (m == 0) ? val_a : (m == 1) ? {12'h000, val_b} : val_c;
  endfunction
  function automatic logic [3:0] in_dp(int m);
    return (m == 0) ? dpi_a : (m == 1) ? {3'b000, dpi_b} : dpi_c;
  endfunction

  task automatic model_step(int m);
    int fl, pc, id;
    bit wrap;
    logic [6:0] s;
    logic d;
    logic [3:0] g, dmask;
    logic [15:0] upper;
    fl = NDV[m] * SDV[m];
    pc = tick[m] % SDV[m];
    id = (tick[m] / SDV[m]) % NDV[m];
    dmask = (NDV[m] == 4) ? 4'hF : 4'h1;
    s = 7'h00; d = 1'b0; g = 4'h0;
    if (!rst_n) begin
      tick[m] = 0; shown[m] = '0; shdp[m] = '0; held[m] = '0; hldp[m] = '0; pend[m] = 0;
    end else begin
      if (en && pc >= BLV[m]) begin
        upper = shown[m] >> (4 * id);
        g = 4'(1 << id);
        s = DEC[upper[3:0]];
`ifdef SEG7_LZ_BLANK_EN
        if (id > 0 && upper == 16'h0) s = 7'h00;
`endif
        d = shdp[m][id];
      end
      wrap = en && (tick[m] % fl == fl - 1);
      if (en) tick[m] = (tick[m] + 1) % fl;
      if (wrap && in_load(m)) begin
        shown[m] = in_val(m); shdp[m] = in_dp(m); pend[m] = 0;
      end else begin
        if (wrap && pend[m]) begin
          shown[m] = held[m]; shdp[m] = hldp[m]; pend[m] = 0;
        end
        if (in_load(m)) begin
          held[m] = in_val(m); hldp[m] = in_dp(m); pend[m] = 1;
        end
      end
    end
    if (ALV[m] != 0) begin
      s = ~s; d = ~d; g = ~g & dmask;
    end
    e_seg[m] = s; e_dp[m] = d; e_dig[m] = g;
  endtask

  always @(posedge clk) begin
    for (int m = 0; m < 3; m++) model_step(m);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [6:0] os;
    logic od, ofd, efd;
    logic [3:0] og;
    int fl;
    for (int m = 0; m < 3; m++) begin
      os  = (m == 0) ? seg_a : (m == 1) ? seg_b : seg_c;
      od  = (m == 0) ? dp_a  : (m == 1) ? dp_b  : dp_c;
      og  = (m == 0) ? dig_a : (m == 1) ? {3'b000, dig_b} : dig_c;
      ofd = (m == 0) ? fd_a  : (m == 1) ? fd_b  : fd_c;
      fl  = NDV[m] * SDV[m];
      efd = rst_n && en && (tick[m] % fl == fl - 1);
      chk($sformatf("seg%0d", m), {9'h0, os}, {9'h0, e_seg[m]});
      chk($sformatf("dp%0d", m), {15'h0, od}, {15'h0, e_dp[m]});
      chk($sformatf("dig%0d", m), {12'h0, og}, {12'h0, e_dig[m]});
      chk($sformatf("fd%0d", m), {15'h0, ofd}, {15'h0, efd});
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_fd_a(input string tag);
    bit ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (fd_a) ok = 1;
      else step();
    end
    chk(tag, {15'h0, ok}, 16'h0001);
  endtask

  initial begin
    int c0, cact, cfd;
    bit found;
    rst_n = 0; en = 0;
    load_a = 0; load_b = 0; load_c = 0;
    val_a = '0; val_b = '0; val_c = '0; dpi_a = '0; dpi_b = 0; dpi_c = '0;
    repeat (3) step();
    chk("rst_dig_a", {12'h0, dig_a}, 16'h0000);
    chk("rst_dig_c", {12'h0, dig_c}, 16'h000F);
    chk("rst_seg_c", {9'h0, seg_c}, 16'h007F);
    chk("rst_fd_a", {15'h0, fd_a}, 16'h0000);

    // Decode table through the 1-digit instance; A and C get fixed values.
    rst_n = 1; en = 1;
    load_a = 1; val_a = 16'h1234; dpi_a = 4'b0100;
    load_c = 1; val_c = 16'h0008; dpi_c = 4'b0001;
    for (int v = 0; v < 16; v++) begin
      val_b = 4'(v); dpi_b = v[0]; load_b = 1;
      step();
      load_b = 0; load_a = 0; load_c = 0;
      repeat (4) step();
      chk($sformatf("dec_%0d", v), {9'h0, seg_b}, {9'h0, ~DEC[v]});
    end

    // One full frame of A: each strobe active 3 of 4 cycles, one frame_done.
    wait_fd_a("wait_fd_frame");
    c0 = 0; cact = 0; cfd = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (dig_a == 4'b0001) c0++;
      if (dig_a != 4'b0000) cact++;
      if (fd_a) cfd++;
    end
    chk("dig0_cycles", 16'(c0), 16'd3);
    chk("active_cycles", 16'(cact), 16'd12);
    chk("fd_per_frame", 16'(cfd), 16'd1);

    // Mid-frame load must not tear the frame in progress.
    val_a = 16'h2222; load_a = 1; step(); load_a = 0;
    repeat (40) step();
    wait_fd_a("wait_fd_tear");
    repeat (5) step();
    val_a = 16'h1111; load_a = 1; step(); load_a = 0;
    repeat (30) step();

    // Load exactly on the frame_done cycle.
    wait_fd_a("wait_fd_direct");
    val_a = 16'h5555; load_a = 1; step(); load_a = 0;
    chk("pend_after_direct", {15'h0, pend[0]}, 16'h0000);
    repeat (18) step();

    // Disable for 10 cycles.
    en = 0;
    step();
    for (int i = 0; i < 9; i++) begin
      step();
      chk("dis_dig_a", {12'h0, dig_a}, 16'h0000);
    end
    en = 1;
    repeat (10) step();

    // Active-low digit 0 showing 8: all segments driven low.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (dig_c == 4'b1110) found = 1;
      else step();
    end
    chk("found_c_dig0", {15'h0, found}, 16'h0001);
    chk("c_seg_8", {9'h0, seg_c}, 16'h0000);

    // Reset mid-scan.
    repeat (3) step();
    rst_n = 0; step();
    chk("midrst_dig_c", {12'h0, dig_c}, 16'h000F);
    chk("midrst_dig_a", {12'h0, dig_a}, 16'h0000);
    rst_n = 1;
    repeat (5) step();

    // Leading-zero candidates.
    val_a = 16'h0040; load_a = 1; val_c = 16'h0000; load_c = 1; step();
    load_a = 0; load_c = 0;
    repeat (60) step();

    // Randomized traffic.
    for (int i = 0; i < 900; i++) begin
      en     = ($urandom_range(0, 9) != 0);
      rst_n  = ($urandom_range(0, 199) != 0);
      load_a = ($urandom_range(0, 6) == 0);
      load_b = ($urandom_range(0, 3) == 0);
      load_c = ($urandom_range(0, 6) == 0);
      val_a  = 16'($urandom); val_c = 16'($urandom); val_b = 4'($urandom);
      if ($urandom_range(0, 3) == 0) val_a = {8'h00, 8'($urandom)};
      dpi_a  = 4'($urandom); dpi_c = 4'($urandom); dpi_b = 1'($urandom);
      step();
    end
    rst_n = 1; en = 1; load_a = 0; load_b = 0; load_c = 0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
